// File: rtl/bnn_pkg.sv
// Shared types and constants for the time-multiplexed BNN neuron sequencer.
package bnn_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_ACT,
        LOAD_W,
        LOAD_THR,
        DONE
    } state_t;

    function automatic int unsigned bytes_per_vec(input int unsigned bits);
        return bits / BYTE_W;
    endfunction

endpackage

// File: rtl/bnn_xnor_pop8.sv
// Shared datapath slice: popcount of the bitwise XNOR of one activation byte and one weight byte.
module bnn_xnor_pop8
    import bnn_pkg::*;
(
    input  logic [BYTE_W-1:0] act,
    input  logic [BYTE_W-1:0] weight,
    output logic [3:0]        pop_c
);

    logic [BYTE_W-1:0] match;

    always_comb begin
        match = ~(act ^ weight);
        pop_c = '0;
        for (int i = 0; i < int'(BYTE_W); i++) begin
            pop_c = pop_c + 4'(match[i]);
        end
    end

endmodule

// File: rtl/bnn_neuron_sequencer.sv
// Byte-stream controller that evaluates N_NEURONS binary neurons one after another
// over a single XNOR-popcount slice and thresholds each total to one output bit.
module bnn_neuron_sequencer
    import bnn_pkg::*;
#(
    parameter int unsigned IN_BITS   = 16,
    parameter int unsigned N_NEURONS = 4,
    parameter int unsigned CNT_W     = $clog2(IN_BITS + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 in_valid,
    input  logic [7:0]           in_data,
    output logic                 in_ready,
    output logic                 busy,
    output logic                 out_valid,
    output logic [N_NEURONS-1:0] out_bits
);

    localparam int unsigned BYTES = bytes_per_vec(IN_BITS);
    localparam int unsigned BC_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int unsigned NI_W  = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;

    state_t state;
    state_t next_state;

    logic [BC_W-1:0]    byte_cnt;
    logic [NI_W-1:0]    neuron;
    logic [CNT_W-1:0]   acc;
    logic [IN_BITS-1:0] act_buf;

    logic              xfer_c;
    logic              last_byte_c;
    logic              last_neuron_c;
    logic              thr_hit_c;
    logic [BYTE_W-1:0] act_byte_c;
    logic [3:0]        pop_c;

    assign xfer_c        = in_valid && in_ready;
    assign last_byte_c   = (byte_cnt == BC_W'(BYTES - 1));
    assign last_neuron_c = (neuron == NI_W'(N_NEURONS - 1));
    // Compare in 9 bits so thresholds above IN_BITS are never truncated.
    assign thr_hit_c     = (9'(acc) >= 9'(in_data));

    always_comb begin
        act_byte_c = '0;
        for (int i = 0; i < int'(BYTES); i++) begin
            if (byte_cnt == BC_W'(i)) begin
                act_byte_c = act_buf[i*BYTE_W +: BYTE_W];
            end
        end
    end

    bnn_xnor_pop8 u_pop (
        .act    (act_byte_c),
        .weight (in_data),
        .pop_c  (pop_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (start) next_state = LOAD_ACT;
            LOAD_ACT: if (xfer_c && last_byte_c) next_state = LOAD_W;
            LOAD_W:   if (xfer_c && last_byte_c) next_state = LOAD_THR;
            LOAD_THR: if (xfer_c) next_state = last_neuron_c ? DONE : LOAD_W;
            DONE:     next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    // Handshake/status flags are registered decodes of the upcoming state.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready  <= 1'b0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            in_ready  <= (next_state == LOAD_ACT) || (next_state == LOAD_W) ||
                         (next_state == LOAD_THR);
            busy      <= (next_state != IDLE);
            out_valid <= (next_state == DONE);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            byte_cnt <= '0;
            neuron   <= '0;
            acc      <= '0;
            act_buf  <= '0;
            out_bits <= '0;
        end else begin
            if (state == IDLE && start) begin
                byte_cnt <= '0;
                neuron   <= '0;
                acc      <= '0;
            end
            if (xfer_c) begin
                byte_cnt <= (next_state != state) ? '0 : byte_cnt + BC_W'(1);
                case (state)
                    LOAD_ACT: begin
                        for (int i = 0; i < int'(BYTES); i++) begin
                            if (byte_cnt == BC_W'(i)) begin
                                act_buf[i*BYTE_W +: BYTE_W] <= in_data;
                            end
                        end
                        if (last_byte_c) begin
                            neuron <= '0;
                            acc    <= '0;
                        end
                    end
                    LOAD_W: acc <= acc + CNT_W'(pop_c);
                    LOAD_THR: begin
                        for (int n = 0; n < int'(N_NEURONS); n++) begin
                            if (neuron == NI_W'(n)) begin
                                out_bits[n] <= thr_hit_c;
                            end
                        end
                        acc <= '0;
                        if (!last_neuron_c) begin
                            neuron <= neuron + NI_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bnn_neuron_sequencer.sv
// Directed, table-driven bench for bnn_neuron_sequencer (IN_BITS=16, N_NEURONS=4).
module tb_bnn_neuron_sequencer;

    typedef struct packed {
        logic [15:0] act;       // byte k at [8k +: 8]
        logic [63:0] w;         // neuron n byte k at [16n + 8k +: 8]
        logic [31:0] thr;       // neuron n at [8n +: 8]
        logic [3:0]  exp_bits;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       busy;
    logic       out_valid;
    logic [3:0] out_bits;

    int checks;
    int failures;
    int xfers;
    int pulses;
    int ready_drops;
    logic [3:0] last_bits;
    vec_t vecs [6];

    bnn_neuron_sequencer #(.IN_BITS(16), .N_NEURONS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .busy      (busy),
        .out_valid (out_valid),
        .out_bits  (out_bits)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (in_valid && in_ready) xfers++;
        if (out_valid) pulses++;
        if (busy && !out_valid && !in_ready) ready_drops++;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d, input int unsigned gap_pct, input logic start_lvl);
        int guard;
        while ($urandom_range(99) < gap_pct) begin
            in_valid = 1'b0;
            step();
        end
        in_valid = 1'b1;
        in_data  = d;
        start    = start_lvl;
        guard    = 0;
        while (!in_ready && guard < 20) begin
            step();
            guard++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout: in_ready stuck at 0 for byte %0h", d);
        end
        step();
        in_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic run_layer(input vec_t v, input int unsigned gap, input logic start_in_w,
                             input logic start_in_done, input string tag);
        int x0;
        int p0;
        x0 = xfers;
        p0 = pulses;
        ready_drops = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        check({tag, "_busy_start"}, 32'(busy), 32'd1);
        for (int k = 0; k < 2; k++) send_byte(v.act[8*k +: 8], gap, 1'b0);
        check({tag, "_hold_bits"}, 32'(out_bits), 32'(last_bits));
        for (int n = 0; n < 4; n++) begin
            for (int k = 0; k < 2; k++) send_byte(v.w[16*n + 8*k +: 8], gap, start_in_w);
            send_byte(v.thr[8*n +: 8], gap, 1'b0);
        end
        check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_out_bits"}, 32'(out_bits), 32'(v.exp_bits));
        check({tag, "_xfers"}, 32'(xfers - x0), 32'd14);
        start = start_in_done;
        step();
        start = 1'b0;
        check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
        check({tag, "_pulses"}, 32'(pulses - p0), 32'd1);
        check({tag, "_ready_drops"}, 32'(ready_drops), 32'd0);
        step();
        check({tag, "_bits_held"}, 32'(out_bits), 32'(v.exp_bits));
        check({tag, "_stay_idle"}, 32'(busy), 32'd0);
        last_bits = v.exp_bits;
    endtask

    initial begin
        int x0;
        int p0;
        checks    = 0;
        failures  = 0;
        xfers     = 0;
        pulses    = 0;
        last_bits = 4'b0000;
        rst       = 1'b1;
        start     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;

        vecs[0] = '{act: 16'hFFFF, w: {16'h00F0, 16'h0F0F, 16'h0000, 16'hFFFF},
                    thr: {8'h05, 8'h08, 8'h01, 8'h10}, exp_bits: 4'b0101};
        vecs[1] = '{act: 16'hA53C, w: {4{16'hA53C}}, thr: 32'h0, exp_bits: 4'b1111};
        vecs[2] = '{act: 16'hA53C, w: {4{16'h5AC3}}, thr: 32'h0, exp_bits: 4'b1111};
        vecs[3] = '{act: 16'hA53C, w: {4{16'hA53C}}, thr: {4{8'h11}}, exp_bits: 4'b0000};
        vecs[4] = '{act: 16'h0000, w: 64'h0, thr: {4{8'h10}}, exp_bits: 4'b1111};
        vecs[5] = '{act: 16'h00FF, w: {16'hFFFF, 16'h0000, 16'hFF00, 16'h00FF},
                    thr: {8'h08, 8'h09, 8'h00, 8'h11}, exp_bits: 4'b1010};

        step(); step(); step();
        rst = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_bits", 32'(out_bits), 32'd0);

        // Bytes offered while idle are not taken.
        x0 = xfers;
        in_valid = 1'b1;
        in_data  = 8'hAA;
        for (int i = 0; i < 3; i++) begin
            check("idle_ready", 32'(in_ready), 32'd0);
            step();
        end
        in_valid = 1'b0;
        check("idle_xfers", 32'(xfers - x0), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);

        for (int i = 0; i < 6; i++) begin
            run_layer(vecs[i], 0, 1'b0, 1'b0, $sformatf("vec%0d", i));
        end

        run_layer(vecs[0], 50, 1'b0, 1'b0, "backpressure");
        run_layer(vecs[5], 0, 1'b1, 1'b0, "start_in_w");
        run_layer(vecs[0], 0, 1'b0, 1'b1, "start_in_done");

        // Reset after six transfers discards the partial run.
        p0 = pulses;
        start = 1'b1;
        step();
        start = 1'b0;
        send_byte(vecs[0].act[7:0], 0, 1'b0);
        send_byte(vecs[0].act[15:8], 0, 1'b0);
        send_byte(vecs[0].w[7:0], 0, 1'b0);
        send_byte(vecs[0].w[15:8], 0, 1'b0);
        send_byte(vecs[0].thr[7:0], 0, 1'b0);
        send_byte(vecs[0].w[23:16], 0, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_ready", 32'(in_ready), 32'd0);
        check("mid_rst_bits", 32'(out_bits), 32'd0);
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        step(); step();
        check("mid_rst_pulses", 32'(pulses - p0), 32'd0);
        last_bits = 4'b0000;
        run_layer(vecs[0], 0, 1'b0, 1'b0, "after_rst");

        // Back-to-back runs: first result must hold while the second one loads.
        run_layer(vecs[4], 0, 1'b0, 1'b0, "b2b_second");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
